// File: rtl/ula_pkg.sv
// Shared ULA definitions: opcodes, flag positions, default width.
package ula_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    ULA_ADD = 2'b00,
    ULA_ADC = 2'b01,
    ULA_SUB = 2'b10
  } ula_op_e;

  localparam int FLAG_C = 0;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_W = 3;

  typedef logic [FLAG_W-1:0] ula_flags_t;

  function automatic ula_flags_t pack_flags(
    input logic c,
    input logic v,
    input logic z
  );
    ula_flags_t f;
    f = '0;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    f[FLAG_Z] = z;
    return f;
  endfunction

endpackage

// File: rtl/somador_chunk.sv
// Combinational W-bit chunk adder with carry out and carry into the MSB.
module somador_chunk #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_cin,
  output logic [W-1:0] o_s,
  output logic         o_cout,
  output logic         o_cmsb
);

  logic [W:0] w_sum;

  assign w_sum  = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, i_cin};
  assign o_s    = w_sum[W-1:0];
  assign o_cout = w_sum[W];
  // sum bit = a ^ b ^ carry-in, so the carry into the MSB falls out directly
  assign o_cmsb = i_a[W-1] ^ i_b[W-1] ^ w_sum[W-1];

endmodule

// File: rtl/somador_pipeline.sv
// Pipelined add/adc/sub: carry chain cut into STAGES chunks, one per register.
module somador_pipeline
  import ula_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Soma,
  output logic             Cout,
  output logic             overflow,
  output logic             zero
);

  localparam int CHUNK = WIDTH / STAGES;

  if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH ||
      (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("somador_pipeline: illegal WIDTH/STAGES");
  end

  logic             w_en;
  logic [WIDTH-1:0] w_beff;

  assign w_beff = sub ? ~B : B;

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int RW = WIDTH - (k + 1) * CHUNK;
    localparam int DW = (k + 1) * CHUNK;

    logic [CHUNK-1:0] w_a;
    logic [CHUNK-1:0] w_b;
    logic [CHUNK-1:0] w_s;
    logic             w_ci;
    logic             w_co;
    logic             w_cm;
    logic             w_zi;
    logic             w_vi;
    logic [DW-1:0]    w_res;

    logic             r_v;
    logic             r_c;
    logic             r_z;
    logic [DW-1:0]    r_res;

    if (k == 0) begin : g_in
      assign w_a   = A[CHUNK-1:0];
      assign w_b   = w_beff[CHUNK-1:0];
      assign w_ci  = sub | Cin;
      assign w_zi  = 1'b1;
      assign w_vi  = in_valid;
      assign w_res = w_s;
    end else begin : g_in
      assign w_a   = g_st[k-1].g_op.r_a[CHUNK-1:0];
      assign w_b   = g_st[k-1].g_op.r_b[CHUNK-1:0];
      assign w_ci  = g_st[k-1].r_c;
      assign w_zi  = g_st[k-1].r_z;
      assign w_vi  = g_st[k-1].r_v;
      assign w_res = {w_s, g_st[k-1].r_res};
    end

    somador_chunk #(
      .W(CHUNK)
    ) u_chunk (
      .i_a   (w_a),
      .i_b   (w_b),
      .i_cin (w_ci),
      .o_s   (w_s),
      .o_cout(w_co),
      .o_cmsb(w_cm)
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_v   <= 1'b0;
        r_c   <= 1'b0;
        r_z   <= 1'b0;
        r_res <= '0;
      end else if (w_en) begin
        r_v   <= w_vi;
        r_c   <= w_co;
        r_z   <= w_zi & ~|w_s;
        r_res <= w_res;
      end
    end

    // operand bits not yet consumed travel forward, low chunk first
    if (RW > 0) begin : g_op
      logic [RW-1:0] w_ha;
      logic [RW-1:0] w_hb;
      logic [RW-1:0] r_a;
      logic [RW-1:0] r_b;

      if (k == 0) begin : g_src
        assign w_ha = A[WIDTH-1:CHUNK];
        assign w_hb = w_beff[WIDTH-1:CHUNK];
      end else begin : g_src
        assign w_ha = g_st[k-1].g_op.r_a[RW+CHUNK-1:CHUNK];
        assign w_hb = g_st[k-1].g_op.r_b[RW+CHUNK-1:CHUNK];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_en) begin
          r_a <= w_ha;
          r_b <= w_hb;
        end
      end
    end

    if (k == STAGES - 1) begin : g_last
      logic r_cm;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cm <= 1'b0;
        end else if (w_en) begin
          r_cm <= w_cm;
        end
      end
    end
  end

  assign out_valid = g_st[STAGES-1].r_v;
  assign w_en      = !out_valid || out_ready;
  assign in_ready  = w_en;
  assign Soma      = g_st[STAGES-1].r_res;
  assign Cout      = g_st[STAGES-1].r_c;
  assign overflow  = g_st[STAGES-1].r_c ^ g_st[STAGES-1].g_last.r_cm;
  assign zero      = g_st[STAGES-1].r_z;

endmodule

// File: tb/tb_somador_pipeline.sv
// Scoreboard bench for somador_pipeline at 32/4, 8/1 and 8/8.
module tb_somador_pipeline;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit done [3];

  task automatic check(
    input bit          ok,
    input string       nm,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_cfg
    localparam int W = (g == 0) ? 32 : 8;
    localparam int S = (g == 0) ? 4 : ((g == 1) ? 1 : 8);

    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic         cout;
    logic         ovf;
    logic         zero;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] soma;
    logic [W+2:0] q [$];
    int           cyc;
    int           st_lo;
    int           st_hi;
    bit           rnd;

    somador_pipeline #(
      .WIDTH (W),
      .STAGES(S)
    ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .A        (a),
      .B        (b),
      .Cin      (cin),
      .sub      (sub),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .Soma     (soma),
      .Cout     (cout),
      .overflow (ovf),
      .zero     (zero)
    );

    // integer-arithmetic reference: {sum, carry, overflow, zero}
    function automatic logic [W+2:0] model(
      input logic [W-1:0] x,
      input logic [W-1:0] y,
      input logic         c,
      input logic         s
    );
      longint lim, ux, uy, sx, sy, full, sfull;
      logic [W-1:0] r;
      logic co, v;
      lim = longint'(1) << (W - 1);
      ux = longint'(x);
      uy = longint'(y);
      sx = x[W-1] ? ux - (lim << 1) : ux;
      sy = y[W-1] ? uy - (lim << 1) : uy;
      if (s) begin
        full  = ux - uy;
        co    = (ux >= uy);
        sfull = sx - sy;
      end else begin
        full  = ux + uy + longint'(c);
        co    = (full >= (lim << 1));
        sfull = sx + sy + longint'(c);
      end
      v = (sfull >= lim) || (sfull < -lim);
      r = full[W-1:0];
      return {r, co, v, (r == '0)};
    endfunction

    task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      if (rnd) out_ready = ($urandom_range(3) != 0);
      else     out_ready = !(cyc >= st_lo && cyc <= st_hi);
    endtask

    task automatic send(
      input logic [W-1:0] x,
      input logic [W-1:0] y,
      input logic         c,
      input logic         s
    );
      bit acc;
      int n;
      a = x; b = y; cin = c; sub = s;
      in_valid = 1'b1;
      acc = 1'b0;
      n = 0;
      while (!acc && n < 100) begin
        @(negedge clk);
        acc = in_ready;
        step();
        n++;
        if (acc) q.push_back(model(x, y, c, s));
      end
      in_valid = 1'b0;
      if (!acc) check(1'b0, "accept_timeout", 64'(n), 64'(0));
    endtask

    task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 400) begin
        step();
        n++;
      end
      check(q.size() == 0, "drain", 64'(q.size()), 64'(0));
    endtask

    always @(negedge clk) begin
      if (rst_n === 1'b1) begin
        check(in_ready === (!out_valid || out_ready), "in_ready",
              64'(in_ready), 64'(!out_valid || out_ready));
        if (out_valid === 1'b1) begin
          if (q.size() == 0) begin
            check(1'b0, "extra_beat", 64'(soma), 64'(0));
          end else begin
            check({soma, cout, ovf, zero} === q[0],
                  out_ready ? "result" : "stall_hold",
                  64'({soma, cout, ovf, zero}), 64'(q[0]));
            if (out_ready) void'(q.pop_front());
          end
        end
      end
    end

    initial begin
      logic [W-1:0] ones, maxp, minn, one, k;
      ones = '1;
      maxp = {1'b0, {(W-1){1'b1}}};
      minn = {1'b1, {(W-1){1'b0}}};
      one  = W'(1);
      k    = W'(32'h1234_5678);
      rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0;
      cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
      rnd = 1'b0; st_lo = -1; st_hi = -2; cyc = 0;
      repeat (3) @(posedge clk);
      #1;
      check(out_valid === 1'b0, "rst_valid", 64'(out_valid), 64'(0));
      check(soma === '0, "rst_soma", 64'(soma), 64'(0));
      check(cout === 1'b0, "rst_cout", 64'(cout), 64'(0));
      check(ovf === 1'b0, "rst_ovf", 64'(ovf), 64'(0));
      check(zero === 1'b0, "rst_zero", 64'(zero), 64'(0));
      check(in_ready === 1'b1, "rst_in_ready", 64'(in_ready), 64'(1));
      rst_n = 1'b1;
      step();

      send(W'(5), W'(3), 1'b0, 1'b0);
      send(ones, one, 1'b0, 1'b0);
      send(W'(3), W'(5), 1'b0, 1'b1);
      send(k, k, 1'b0, 1'b1);
      send(maxp, one, 1'b0, 1'b0);
      send(minn, one, 1'b0, 1'b1);
      send(W'(5), W'(3), 1'b1, 1'b0);
      send(W'(5), W'(3), 1'b1, 1'b1);
      send(ones, ones, 1'b1, 1'b0);
      drain();

      st_lo = cyc + 6;
      st_hi = cyc + 8;
      for (int i = 0; i < 8; i++) send(W'(i), W'(i), i[0], 1'b0);
      drain();
      st_lo = -1;
      st_hi = -2;

      for (int i = 0; i < 3; i++)
        send(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
      rst_n = 1'b0;
      #1;
      check(out_valid === 1'b0, "midrst_valid", 64'(out_valid), 64'(0));
      check(soma === '0, "midrst_soma", 64'(soma), 64'(0));
      q.delete();
      repeat (2) step();
      rst_n = 1'b1;
      repeat (2 * S + 10) step();
      check(q.size() == 0, "midrst_empty", 64'(q.size()), 64'(0));

      rnd = 1'b1;
      repeat (150) begin
        if ($urandom_range(3) == 0) step();
        send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      end
      drain();
      rnd = 1'b0;
      done[g] = 1'b1;
    end
  end

  initial begin
    int t;
    t = 0;
    while (!(done[0] && done[1] && done[2]) && t < 20000) begin
      @(posedge clk);
      t++;
    end
    if (t >= 20000) check(1'b0, "global_timeout", 64'(t), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/somador_pipeline.md
Name: somador_pipeline

Overview:
- Parametrised successor to the 32-bit ripple-carry adder. Performs add, add-with-carry and subtract.
- Splits the carry chain into STAGES equal chunks, one chunk per pipeline register stage, giving one result per cycle at STAGES cycles latency.
- Valid/ready handshake on input and output, with backpressure.
- Produces ULA flags: carry, signed overflow, zero. Feeds the ULA result mux.

Parameters:
WIDTH, 32, operand/result width in bits; must be ≥ 2.
STAGES, 4, pipeline depth and number of carry chunks; 1 ≤ STAGES ≤ WIDTH; WIDTH % STAGES == 0 (elaboration error otherwise).

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  operand beat offered.
in_ready  out  1  pipeline accepts a beat this cycle.
A  in  WIDTH  operand A.
B  in  WIDTH  operand B.
Cin  in  1  carry-in; ignored when sub=1.
sub  in  1  0 = A+B+Cin; 1 = A-B, i.e. A+~B+1.
out_valid  out  1  result beat present.
out_ready  in  1  consumer accepts result.
Soma  out  WIDTH  sum/difference, mod 2^WIDTH.
Cout  out  1  carry out of MSB; for sub, 1 = no borrow (A ≥ B unsigned).
overflow  out  1  signed overflow = carry into MSB XOR carry out of MSB.
zero  out  1  Soma == 0.

Behaviour:
- CHUNK = WIDTH/STAGES. Stage k (0..STAGES-1) adds bits [k*CHUNK +: CHUNK] of A and Beff, where Beff = sub ? ~B : B.
  - Stage 0 carry-in is sub ? 1 : Cin.
  - Stage k>0 carry-in is the registered carry from stage k-1.
- Each stage register holds:
  - valid bit;
  - completed low result bits;
  - remaining high bits of A and Beff, skewed forward;
  - chunk carry;
  - running zero (AND of per-chunk zero);
  - carry into MSB (meaningful only after the last stage).
- Global enable: en = !out_valid || out_ready. All stages shift together when en=1 and hold when en=0.
- in_ready = en, combinational. A beat is accepted when in_valid && in_ready.
- Stage 0 valid loads in_valid when en=1. Bubbles propagate and are not collapsed.
- Latency: a beat accepted at edge n appears at out_valid after edge n+STAGES-1 (STAGES=1: visible the cycle after acceptance), provided no stall intervenes.
- Throughput: 1 beat/cycle while out_ready=1.
- Stall: while out_valid && !out_ready, all outputs and internal registers hold and in_ready=0. No beat is lost or duplicated.
- Outputs are registered from the last stage. Soma, Cout, overflow and zero are valid only when out_valid=1 and are held stable while stalled.
- Reset (async assert, sync deassert by the caller): all valid bits 0, all data registers 0. Immediately after reset: out_valid=0, Soma=0, Cout=0, overflow=0, zero=0, in_ready=1.
  - Reset mid-operation discards every in-flight beat.
- Order preserved. No internal state beyond the pipeline registers (no FSM beyond the valid chain).
- Width rules:
  - Chunk adder is CHUNK+1 bits wide. Top bit is the chunk carry.
  - Last stage also captures the carry into bit WIDTH-1 for overflow. When CHUNK=1, that carry is the stage carry-in.

Decomposition:
- Shared package (ula_pkg): ULA opcode encodings for ADD/ADC/SUB, flag-vector bit positions (C, V, Z) and the WIDTH default constant.
- One natural sub-module: somador_chunk, a combinational CHUNK-bit adder with carry-in, carry-out and carry-into-MSB outputs. Instantiated once per stage by a generate loop. SOMADOR/meio_somador are not reused.

Test Plan:
- Reset, then A=0x0000_0005, B=0x0000_0003, sub=0, Cin=0, out_ready=1 -> after 4 cycles Soma=0x0000_0008, Cout=0, overflow=0, zero=0.
- Carry across every chunk: A=0xFFFF_FFFF, B=0x0000_0001, Cin=0 -> Soma=0, Cout=1, zero=1, overflow=0.
- Subtract: A=0x0000_0003, B=0x0000_0005, sub=1 -> Soma=0xFFFF_FFFE, Cout=0 (borrow). Then A=B=0x1234_5678, sub=1 -> Soma=0, Cout=1, zero=1.
- Signed overflow: A=0x7FFF_FFFF, B=1 -> Soma=0x8000_0000, overflow=1, Cout=0. Also A=0x8000_0000 minus B=1 -> Soma=0x7FFF_FFFF, overflow=1.
- Back-to-back with backpressure: 8 consecutive beats (A=i, B=i, Cin=i&1); out_ready low for cycles 6-8. Expect outputs 2i+(i&1) in order, no loss or duplication, in_ready=0 exactly while stalled, Soma stable during stall.
- Reset mid-flight with 3 beats in pipe: assert rst_n=0 -> out_valid=0 at once, no result emerges afterwards. Repeat the suite at WIDTH=8, STAGES=1 and WIDTH=8, STAGES=8.
